// File: rtl/cga_pixel_serializer.sv
// Graphics-mode pixel serializer: one-word holding register feeding a shifter
// that emits 1/2/4-bit pixels with programmable repeat and sticky underrun detect.
module cga_pixel_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REP_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              run,
    input  logic [1:0]        bpp_sel,
    input  logic [REP_W-1:0]  rep,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [3:0]        pix_data,
    output logic              pix_valid,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] hold_q;
    logic              hold_full;
    logic [DATA_W-1:0] shift_q;
    logic              active;
    logic [1:0]        bpp_q;
    logic [REP_W-1:0]  rep_q;
    logic [REP_W-1:0]  rep_cnt;
    logic [CNT_W-1:0]  pix_cnt;

    logic [CNT_W-1:0]  last_idx;
    logic [3:0]        field;
    logic [DATA_W-1:0] shifted;
    logic              rep_done;
    logic              word_done;
    logic              unload;
    logic              accept;

    // Per-mode pixel field, shift result and last pixel index of the loaded word
    always_comb begin
        last_idx = CNT_W'(DATA_W / 4 - 1);
        field    = shift_q[DATA_W-1 -: 4];
        shifted  = {shift_q[DATA_W-5:0], 4'b0};
        case (bpp_q)
            2'd0: begin
                last_idx = CNT_W'(DATA_W - 1);
                field    = {3'b0, shift_q[DATA_W-1]};
                shifted  = {shift_q[DATA_W-2:0], 1'b0};
            end
            2'd1: begin
                last_idx = CNT_W'(DATA_W / 2 - 1);
                field    = {2'b0, shift_q[DATA_W-1 -: 2]};
                shifted  = {shift_q[DATA_W-3:0], 2'b0};
            end
            default: ;
        endcase
    end

    assign rep_done   = (rep_cnt == rep_q);
    assign word_done  = active && rep_done && (pix_cnt == last_idx);
    assign unload     = run && hold_full && (!active || word_done);
    assign byte_ready = !hold_full || unload;
    assign accept     = byte_valid && byte_ready && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            active    <= 1'b0;
            bpp_q     <= 2'd0;
            rep_q     <= '0;
            rep_cnt   <= '0;
            pix_cnt   <= '0;
            pix_data  <= 4'd0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else if (clear) begin
            hold_full <= 1'b0;
            active    <= 1'b0;
            rep_cnt   <= '0;
            pix_cnt   <= '0;
            pix_data  <= 4'd0;
            pix_valid <= 1'b0;
        end else begin
            if (run) begin
                if (unload) begin
                    shift_q <= hold_q;
                    bpp_q   <= (bpp_sel == 2'd3) ? 2'd2 : bpp_sel;
                    rep_q   <= rep;
                    rep_cnt <= '0;
                    pix_cnt <= '0;
                    active  <= 1'b1;
                end else if (word_done) begin
                    // Word finished with nothing queued behind it
                    active   <= 1'b0;
                    underrun <= 1'b1;
                end else if (active) begin
                    if (rep_done) begin
                        shift_q <= shifted;
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                pix_valid <= active;
                pix_data  <= active ? field : 4'd0;
            end else begin
                pix_valid <= 1'b0;
                pix_data  <= 4'd0;
            end

            if (accept) begin
                hold_q    <= byte_data;
                hold_full <= 1'b1;
            end else if (unload) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cga_pixel_serializer.sv
// Directed and randomized bench for cga_pixel_serializer, comparing the pixel
// stream against a per-word expansion model.
module tb_cga_pixel_serializer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REP_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              run;
    logic [1:0]        bpp_sel;
    logic [REP_W-1:0]  rep;
    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [3:0]        pix_data;
    logic              pix_valid;
    logic              underrun;

    int checks   = 0;
    int failures = 0;

    logic [3:0] got[$];
    logic [3:0] want[$];
    int         runs[$];
    int         cur_run = 0;

    cga_pixel_serializer #(.DATA_W(DATA_W), .REP_W(REP_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .run(run),
        .bpp_sel(bpp_sel), .rep(rep), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Record every valid pixel and the length of each unbroken valid burst
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            got.push_back(pix_data);
            cur_run = cur_run + 1;
        end else if (cur_run != 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected pixels of one word: MSB field first, each pixel repeated r+1 times
    task automatic model(input logic [7:0] w, input int code, input int r);
        int b;
        int v;
        b = (code == 0) ? 1 : (code == 1) ? 2 : 4;
        for (int p = 0; p < 8 / b; p++) begin
            v = (int'(w) >> (8 - (p + 1) * b)) & ((1 << b) - 1);
            for (int k = 0; k <= r; k++) want.push_back(4'(v));
        end
    endtask

    task automatic send(input logic [7:0] w, input bit rand_run);
        bit done;
        done = 1'b0;
        byte_data  = w;
        byte_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rand_run) run = ($urandom_range(3) != 0);
            #1;
            if (byte_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        run = 1'b1;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && got.size() < want.size(); i++) step();
        repeat (3) step();
        check({tag, "_len"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++)
            check({tag, "_pix"}, 32'(got[i]), 32'(want[i]));
    endtask

    task automatic clr_logs();
        got.delete();
        want.delete();
        runs.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        int         bc;
        int         rc;
        int         nw;
        reset = 1'b1; clear = 1'b0; run = 1'b1; bpp_sel = 2'd0; rep = '0;
        byte_data = '0; byte_valid = 1'b0;
        step();
        step();
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;

        // Single 2bpp word: two-clock latency, four pixels, then underrun
        bpp_sel = 2'd1; rep = 2'd0;
        clr_logs();
        send(8'hE4, 1'b0);
        check("t1_lat0", 32'(pix_valid), 32'd0);
        step();
        check("t1_lat1", 32'(pix_valid), 32'd0);
        step();
        check("t1_p0v", 32'(pix_valid), 32'd1);
        check("t1_p0", 32'(pix_data), 32'd3);
        step();
        check("t1_p1", 32'(pix_data), 32'd2);
        step();
        check("t1_p2", 32'(pix_data), 32'd1);
        check("t1_ur_early", 32'(underrun), 32'd0);
        step();
        check("t1_p3", 32'(pix_data), 32'd0);
        check("t1_p3v", 32'(pix_valid), 32'd1);
        step();
        check("t1_endv", 32'(pix_valid), 32'd0);
        check("t1_endd", 32'(pix_data), 32'd0);
        check("t1_ur", 32'(underrun), 32'd1);

        // 1bpp doubled pixels, two back-to-back words with no gap
        do_reset();
        bpp_sel = 2'd0; rep = 2'd1;
        clr_logs();
        send(8'hA5, 1'b0);
        send(8'hFF, 1'b0);
        model(8'hA5, 0, 1);
        model(8'hFF, 0, 1);
        for (int i = 0; i < 100 && got.size() < 30; i++) step();
        check("t2_ur_mid", 32'(underrun), 32'd0);
        drain("t2");
        check("t2_bursts", 32'(runs.size()), 32'd1);
        if (runs.size() > 0) check("t2_burst_len", 32'(runs[0]), 32'd32);
        check("t2_ur_end", 32'(underrun), 32'd1);

        // 4bpp streamed words; ready drops only while hold is full mid-word
        do_reset();
        bpp_sel = 2'd2; rep = 2'd0;
        clr_logs();
        byte_data = 8'h3C; byte_valid = 1'b1;
        step();
        byte_data = 8'h5A;
        #1;
        check("t3_ready_load", 32'(byte_ready), 32'd1);
        step();
        byte_valid = 1'b0;
        check("t3_ready_busy", 32'(byte_ready), 32'd0);
        step();
        check("t3_ready_last", 32'(byte_ready), 32'd1);
        want.push_back(4'h3); want.push_back(4'hC);
        want.push_back(4'h5); want.push_back(4'hA);
        drain("t3");
        check("t3_bursts", 32'(runs.size()), 32'd1);

        // run pause after the second pixel resumes without loss or repeat
        do_reset();
        bpp_sel = 2'd1; rep = 2'd0;
        clr_logs();
        send(8'hE4, 1'b0);
        step();
        step();
        step();
        check("t4_before", 32'(pix_data), 32'd2);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_frozen", 32'(pix_valid), 32'd0);
        end
        run = 1'b1;
        step();
        check("t4_resume", 32'(pix_data), 32'd1);
        check("t4_resume_v", 32'(pix_valid), 32'd1);
        model(8'hE4, 1, 0);
        drain("t4");
        check("t4_bursts", 32'(runs.size()), 32'd2);

        // reset mid-word with a pending word clears everything incl. underrun
        bpp_sel = 2'd0; rep = 2'd3;
        send(8'hA5, 1'b0);
        send(8'h0F, 1'b0);
        repeat (3) step();
        check("t5_pending", 32'(byte_ready), 32'd0);
        check("t5_ur_pre", 32'(underrun), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_rst_v", 32'(pix_valid), 32'd0);
        check("t5_rst_ready", 32'(byte_ready), 32'd1);
        check("t5_rst_ur", 32'(underrun), 32'd0);
        clr_logs();
        repeat (4) step();
        check("t5_rst_quiet", 32'(got.size()), 32'd0);

        // clear mid-word flushes hold, discards a same-cycle word, keeps underrun
        bpp_sel = 2'd2; rep = 2'd0;
        send(8'h12, 1'b0);
        repeat (6) step();
        check("t5_ur_set", 32'(underrun), 32'd1);
        bpp_sel = 2'd0; rep = 2'd3;
        send(8'hA5, 1'b0);
        send(8'h0F, 1'b0);
        repeat (3) step();
        check("t5_pending2", 32'(byte_ready), 32'd0);
        clear = 1'b1; byte_data = 8'h77; byte_valid = 1'b1;
        step();
        clear = 1'b0; byte_valid = 1'b0;
        check("t5_clr_v", 32'(pix_valid), 32'd0);
        check("t5_clr_d", 32'(pix_data), 32'd0);
        check("t5_clr_ready", 32'(byte_ready), 32'd1);
        check("t5_clr_ur", 32'(underrun), 32'd1);
        clr_logs();
        repeat (6) step();
        check("t5_clr_quiet", 32'(got.size()), 32'd0);

        // Randomized phases: random mode, words, gaps and run pauses
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            bc = int'($urandom_range(3));
            rc = int'($urandom_range(3));
            nw = int'($urandom_range(1, 5));
            bpp_sel = 2'(bc);
            rep = REP_W'(rc);
            clr_logs();
            for (int k = 0; k < nw; k++) begin
                w = 8'($urandom);
                model(w, (bc == 3) ? 2 : bc, rc);
                send(w, 1'b1);
                for (int g = 0; g < int'($urandom_range(2)); g++) begin
                    run = ($urandom_range(1) != 0);
                    step();
                end
                run = 1'b1;
            end
            drain("rnd");
            check("rnd_ur", 32'(underrun), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
